// File: rtl/reduction_mux_sched_pkg.sv
// Shared types and entry-layout helpers for the reduction-mux select sequencer.
// Entry layout, LSB first: sel_l, sel_r, zero_l, zero_r, last.
package red_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SEL_L_LSB = 0;

    function automatic int sel_r_lsb(input int sel_in);
        return sel_in / 2;
    endfunction

    function automatic int zero_l_bit(input int sel_in);
        return sel_in;
    endfunction

    function automatic int zero_r_bit(input int sel_in);
        return sel_in + 1;
    endfunction

    function automatic int last_bit(input int sel_in);
        return sel_in + 2;
    endfunction

    function automatic int entry_width(input int sel_in);
        return sel_in + 3;
    endfunction

endpackage

// File: rtl/reduction_mux_sched_mem.sv
// Schedule storage: DEPTH x EW flops, one write port, async read.
// A write to entry 0 is forwarded to a same-cycle read of entry 0 so start sees fresh data.
module red_sched_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int EW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem_q [DEPTH];

    // Storage write port; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Async read with the entry-0 write-through bypass.
    always_comb begin
        rdata = mem_q[raddr];
        if (we && (waddr == '0) && (raddr == '0)) begin
            rdata = wdata;
        end else begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/reduction_mux_sched.sv
// Walks a host-programmed select schedule with a valid/ready handshake and
// legalises each half so the reduction mux never sees an out-of-range index.
module reduction_mux_sched
    import red_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_IN = 2,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int EW     = entry_width(SEL_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [EW-1:0]     cfg_wdata,
    input  logic              start,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [SEL_IN-1:0] o_sel,
    output logic [1:0]        o_zero,
    output logic [AW-1:0]     o_step,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int HW         = SEL_IN / 2;
    localparam int SEL_R_LSB  = sel_r_lsb(SEL_IN);
    localparam int ZERO_L_BIT = zero_l_bit(SEL_IN);
    localparam int ZERO_R_BIT = zero_r_bit(SEL_IN);
    localparam int LAST_BIT   = last_bit(SEL_IN);

    // Returns {zero_out, sel_out}: masked halves present index 0 with the gate set.
    function automatic logic [HW:0] legal_half(input logic [HW-1:0] sel, input logic zero);
        if (zero || (int'(sel) >= (NUM_IN / 2))) begin
            return {1'b1, {HW{1'b0}}};
        end else begin
            return {1'b0, sel};
        end
    endfunction

    state_e            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic              valid_q, valid_d;
    logic [SEL_IN-1:0] sel_q, sel_d;
    logic [1:0]        zero_q, zero_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              mem_we_s;
    logic [AW-1:0]     rd_addr_s;
    logic [EW-1:0]     rd_data_s;
    logic [HW:0]       legal_l_s, legal_r_s;
    logic [SEL_IN-1:0] ld_sel_s;
    logic [1:0]        ld_zero_s;
    logic              ld_last_s;

    assign mem_we_s = cfg_we && (state_q == ST_IDLE);

    red_sched_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .EW    (EW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Look one entry ahead while running; at step DEPTH-1 the wrapped address is never loaded.
    always_comb begin
        if (state_q == ST_RUN) begin
            rd_addr_s = step_q + AW'(1);
        end else begin
            rd_addr_s = '0;
        end
    end

    assign legal_l_s = legal_half(rd_data_s[SEL_L_LSB +: HW], rd_data_s[ZERO_L_BIT]);
    assign legal_r_s = legal_half(rd_data_s[SEL_R_LSB +: HW], rd_data_s[ZERO_R_BIT]);
    assign ld_sel_s  = {legal_r_s[HW-1:0], legal_l_s[HW-1:0]};
    assign ld_zero_s = {legal_r_s[HW], legal_l_s[HW]};
    assign ld_last_s = rd_data_s[LAST_BIT];

    // Next-state and next-output logic for the IDLE -> RUN -> DONE walk.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        zero_d  = zero_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    step_d  = '0;
                    sel_d   = ld_sel_s;
                    zero_d  = ld_zero_s;
                    last_d  = ld_last_s;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (valid_q && i_ready) begin
                    if (last_q || (step_q == AW'(DEPTH - 1))) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + AW'(1);
                        sel_d  = ld_sel_s;
                        zero_d = ld_zero_s;
                        last_d = ld_last_s;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            zero_q  <= 2'b00;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            zero_q  <= zero_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_valid = valid_q;
    assign o_sel   = sel_q;
    assign o_zero  = zero_q;
    assign o_step  = step_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule
